vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
// Shares the single-port frame-buffer RAM between the VGA scan-out prefetcher and the
// PPU pixel writer. Sits between the VGA timing generator (frame_end) and the external
// pixel FIFO that feeds the DAC. Scan-out reads are deadline-driven and flow-controlled
// by a credit counter matching FIFO space; PPU writes fill idle slots, with an anti-starvation override.
// PARAMETERS
// ADDR_W      16   frame-buffer word address width
// DATA_W      6    pixel width (NES palette index)
// FB_WORDS    61440 pixels per frame (256x240); prefetch addresses run 0..FB_WORDS-1
// FIFO_DEPTH  16   downstream pixel FIFO depth = initial/maximum read credits
// WR_STARVE   8    consecutive denied write-request cycles before a forced write grant
// PORTS
// clk        in   1       system clock
// rst        in   1       synchronous active-high reset
// frame_end  in   1       1-cycle pulse from VGA timing: start prefetch of next frame
// pix_pop    in   1       downstream FIFO consumed one pixel (returns one credit)
// wr_req     in   1       PPU write request; hold until wr_ack
// wr_addr    in   ADDR_W  PPU write address (stable while wr_req)
// wr_data    in   DATA_W  PPU write data (stable while wr_req)
// wr_ack     out  1       1-cycle pulse: write committed to RAM this cycle
// mem_addr   out  ADDR_W  RAM address (registered)
// mem_we     out  1       RAM write enable (registered)
// mem_wdata  out  DATA_W  RAM write data (registered)
// mem_rdata  in   DATA_W  RAM read data, valid 1 cycle after a read on mem_addr
// pix_valid  out  1       pix_data valid; push into downstream FIFO
// pix_data   out  DATA_W  prefetched pixel
// credit_err out  1       sticky: pix_pop seen with credits already at FIFO_DEPTH
// BEHAVIOUR
// Reset (rst=1 at clk edge): state=IDLE, rd_ptr=0, credits=FIFO_DEPTH, starve_cnt=0;
//   mem_addr=0, mem_we=0, mem_wdata=0, wr_ack=0, pix_valid=0, pix_data=0, credit_err=0;
//   read pipeline cleared (in-flight read discarded; no pix_valid after reset).
// Prefetch FSM: IDLE -frame_end-> FETCH; FETCH -last address issued-> DONE;
//   DONE -frame_end-> FETCH. frame_end in FETCH: rd_ptr restarts at 0, stays FETCH
//   (early frame; in-flight reads still delivered, credits unchanged). frame_end sets rd_ptr=0.
// rd_want = (state==FETCH) && (credits!=0).
// Arbitration each cycle N (decision registered onto mem_* in N+1):
//   force_wr = wr_req && (starve_cnt==WR_STARVE)
//   grant write if force_wr, else if wr_req && !rd_want; grant read if rd_want && !write grant.
//   A write already acknowledged is not re-granted: wr_req sampled in the wr_ack cycle is ignored.
// Write grant in N: N+1 mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
// Read grant in N: N+1 mem_we=0, mem_addr=rd_ptr; rd_ptr++; credits--;
//   rd_ptr==FB_WORDS-1 issued -> DONE. N+2 pix_valid=1, pix_data=mem_rdata.
//   Latency grant->pix_valid = 2 cycles; throughput 1 pixel/cycle when credits allow.
// No grant: mem_we=0, mem_addr holds previous value.
// credits: width clog2(FIFO_DEPTH+1); read issue & pix_pop same cycle -> unchanged;
//   pix_pop alone at FIFO_DEPTH -> unchanged, credit_err<=1 (cleared only by rst).
//   Never underflows: no read issued at credits==0.
// starve_cnt: ++ (saturate at WR_STARVE) each cycle wr_req high and not granted;
//   0 on write grant or wr_req low.
// rst mid-frame: everything returns to reset state; waits for next frame_end.
// TESTING
// 1 rst then frame_end, pix_pop tied 0 -> exactly 16 reads (addr 0..15), pix_valid 16x, then stall.
// 2 pix_pop every cycle after fill -> continuous reads; addr 61439 issued, FSM DONE, no further reads.
// 3 wr_req held during full-rate prefetch -> wr_ack on 9th cycle (WR_STARVE=8), mem_we=1 with held addr/data; prefetch resumes next cycle.
// 4 wr_req while credits=0 -> wr_ack 1 cycle after req; RAM readback shows written data at wr_addr.
// 5 pix_pop with credits=16 -> credit_err=1 and stays 1; credits remain 16.
// 6 frame_end at rd_ptr=100 -> next read addr 0; rst mid-FETCH -> all outputs zero, no pix_valid until frame_end.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port frame buffer between VGA
// scan-out prefetch (credit flow-controlled) and PPU pixel writes.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 6,
  parameter int FB_WORDS   = 61440,
  parameter int FIFO_DEPTH = 16,
  parameter int WR_STARVE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_end,
  input  logic              pix_pop,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              credit_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(WR_STARVE + 1);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(FB_WORDS - 1);
  localparam logic [CW-1:0] CMAX = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(WR_STARVE);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     credits;
  logic [SW-1:0]     starve_cnt;

  logic wr_eff;
  logic rd_want;
  logic force_wr;
  logic wr_gnt;
  logic rd_gnt;
  logic rd_last;
  logic rd_inflight;

  // Arbitration: reads win unless the writer has starved long enough.
  always_comb begin
    wr_eff   = wr_req && !wr_ack;
    rd_want  = (state == FETCH) && (credits != '0);
    force_wr = wr_eff && (starve_cnt == SMAX);
    wr_gnt   = force_wr || (wr_eff && !rd_want);
    rd_gnt   = rd_want && !wr_gnt;
    rd_last  = rd_gnt && (rd_ptr == LAST);
  end

  // Prefetch FSM next-state.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (frame_end) state_nx = FETCH;
      end
      FETCH: begin
        if (frame_end)    state_nx = FETCH;
        else if (rd_last) state_nx = DONE;
      end
      DONE: begin
        if (frame_end) state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Prefetch FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Read pointer: restarts on every frame_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (frame_end) begin
      rd_ptr <= '0;
    end else if (rd_gnt) begin
      rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
    end
  end

  // Credits mirror free space in the downstream FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CMAX;
    end else begin
      unique case ({rd_gnt, pix_pop})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits != CMAX) credits <= credits + 1'b1;
        end
        default: credits <= credits;
      endcase
    end
  end

  // Sticky flag for a pop that returns a credit we never lent.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_err <= 1'b0;
    end else if (pix_pop && !rd_gnt && credits == CMAX) begin
      credit_err <= 1'b1;
    end
  end

  // Consecutive denied-write counter, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!wr_eff || wr_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SMAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered RAM port; address holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
    end else begin
      mem_we <= wr_gnt;
      wr_ack <= wr_gnt;
      if (wr_gnt) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end else if (rd_gnt) begin
        mem_addr <= rd_ptr;
      end
    end
  end

  // Read return pipeline: grant, address cycle, data cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inflight <= 1'b0;
      pix_valid   <= 1'b0;
    end else begin
      rd_inflight <= rd_gnt;
      pix_valid   <= rd_inflight;
    end
  end

  assign pix_data = pix_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: vector table, directed corner sequences and
// randomized traffic against a frame-buffer reference model.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_end = 1'b0;
  logic        pix_pop = 1'b0;
  logic        wr_req = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [5:0]  wr_data = '0;
  logic        wr_ack;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [5:0]  mem_wdata;
  logic [5:0]  mem_rdata;
  logic        pix_valid;
  logic [5:0]  pix_data;
  logic        credit_err;

  localparam int FBW = 61440;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .frame_end(frame_end),
    .pix_pop(pix_pop), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_valid(pix_valid),
    .pix_data(pix_data), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  logic [5:0] ram    [0:65535];
  logic [5:0] memimg [0:65535];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          r, fe, pop, wq;
    logic [15:0] wa;
    logic [5:0]  wd;
    bit          ack, we;
    logic [15:0] addr;
    bit          pv, err;
  } vec_t;

  function automatic vec_t mk(bit r, bit fe, bit pop, bit wq,
                              int wa, int wd, bit ack, bit we,
                              int addr, bit pv, bit err);
    vec_t v;
    v.r = r; v.fe = fe; v.pop = pop; v.wq = wq;
    v.wa = wa[15:0]; v.wd = wd[5:0];
    v.ack = ack; v.we = we; v.addr = addr[15:0];
    v.pv = pv; v.err = err;
    return v;
  endfunction

  // Reference model: frame-level view of prefetch and arbitration.
  int m_state, m_ptr, m_cred, m_starve, m_rd1addr;
  bit m_ack, m_err, m_rd1, e_we, e_pv;
  int e_addr, e_wdata, e_pix;

  task automatic step(input bit r, input bit fe, input bit pop,
                      input bit wq, input logic [15:0] wa,
                      input logic [5:0] wd);
    bit weff, want, frc, wg, rg;
    @(negedge clk);
    rst = r; frame_end = fe; pix_pop = pop;
    wr_req = wq; wr_addr = wa; wr_data = wd;
    if (r) begin
      m_state = 0; m_ptr = 0; m_cred = 16; m_starve = 0;
      m_ack = 0; m_err = 0; m_rd1 = 0;
      e_we = 0; e_addr = 0; e_wdata = 0; e_pv = 0; e_pix = 0;
    end else begin
      e_pv  = m_rd1;
      e_pix = m_rd1 ? int'(memimg[m_rd1addr]) : 0;
      weff = wq && !m_ack;
      want = (m_state == 1) && (m_cred > 0);
      frc  = weff && (m_starve == 8);
      wg   = frc || (weff && !want);
      rg   = want && !wg;
      m_ack = wg;
      e_we  = wg;
      if (wg) begin
        e_addr = int'(wa); e_wdata = int'(wd);
        memimg[wa] = wd;
      end else if (rg) begin
        e_addr = m_ptr;
      end
      m_rd1 = rg;
      if (rg) m_rd1addr = m_ptr;
      if (rg && !pop) m_cred--;
      else if (pop && !rg) begin
        if (m_cred == 16) m_err = 1;
        else m_cred++;
      end
      if (!weff || wg) m_starve = 0;
      else if (m_starve < 8) m_starve++;
      if (rg) begin
        m_ptr++;
        if (m_ptr == FBW) begin
          m_ptr = 0; m_state = 2;
        end
      end
      if (fe) begin
        m_ptr = 0; m_state = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("wr_ack", int'(wr_ack), int'(m_ack));
    chk("mem_we", int'(mem_we), int'(e_we));
    chk("mem_addr", int'(mem_addr), e_addr);
    chk("pix_valid", int'(pix_valid), int'(e_pv));
    chk("credit_err", int'(credit_err), int'(m_err));
    if (e_we) chk("mem_wdata", int'(mem_wdata), e_wdata);
    if (e_pv || r) chk("pix_data", int'(pix_data), e_pix);
    if (pix_valid) pv_cnt++;
  endtask

  vec_t tbl[18];

  initial begin
    int n;
    bit pend;
    logic [15:0] pa;
    logic [5:0]  pd;

    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 6'((i * 7 + 3) ^ (i >> 6));
      memimg[i] = 6'((i * 7 + 3) ^ (i >> 6));
    end

    // Reset, credit overflow, fill start, forced write, reset.
    tbl[0]  = mk(1,0,0,0, 0,0,    0,0, 0,0,0);
    tbl[1]  = mk(0,0,1,0, 0,0,    0,0, 0,0,1);
    tbl[2]  = mk(0,1,0,0, 0,0,    0,0, 0,0,1);
    tbl[3]  = mk(0,0,0,0, 0,0,    0,0, 0,0,1);
    tbl[4]  = mk(0,0,0,0, 0,0,    0,0, 1,1,1);
    for (int k = 5; k <= 12; k++)
      tbl[k] = mk(0,0,0,1, 'h100,'h2A, 0,0, k-3,1,1);
    tbl[13] = mk(0,0,0,1, 'h100,'h2A, 1,1, 'h100,1,1);
    tbl[14] = mk(0,0,0,1, 'h100,'h2A, 0,0, 10,0,1);
    tbl[15] = mk(0,0,0,0, 0,0,    0,0, 11,1,1);
    tbl[16] = mk(1,0,0,0, 0,0,    0,0, 0,0,0);
    tbl[17] = mk(0,0,0,0, 0,0,    0,0, 0,0,0);

    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      rst = tbl[k].r; frame_end = tbl[k].fe;
      pix_pop = tbl[k].pop; wr_req = tbl[k].wq;
      wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_ack", k), int'(wr_ack), int'(tbl[k].ack));
      chk($sformatf("tbl%0d_we", k), int'(mem_we), int'(tbl[k].we));
      chk($sformatf("tbl%0d_addr", k), int'(mem_addr), int'(tbl[k].addr));
      chk($sformatf("tbl%0d_pv", k), int'(pix_valid), int'(tbl[k].pv));
      chk($sformatf("tbl%0d_err", k), int'(credit_err), int'(tbl[k].err));
      if (tbl[k].ack) memimg[tbl[k].wa] = tbl[k].wd;
    end

    // Fill with no pops: exactly FIFO_DEPTH reads then stall.
    step(1,0,0,0,0,0);
    step(0,1,0,0,0,0);
    pv_cnt = 0;
    for (int i = 0; i < 30; i++) step(0,0,0,0,0,0);
    chk("fill_pix_count", pv_cnt, 16);
    chk("fill_last_addr", int'(mem_addr), 15);

    // Write with zero credits is granted immediately.
    step(0,0,0,1,16'd3,6'h15);
    chk("nocredit_ack", int'(wr_ack), 1);
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);
    chk("ram_written", int'(ram[3]), 'h15);

    // Read back through prefetch, then early frame_end at 100.
    step(0,1,1,0,0,0);
    for (int i = 0; i < 400 && m_ptr != 100; i++)
      step(0,0,1,0,0,0);
    chk("ptr_at_100", int'(mem_addr), 99);
    step(0,1,1,0,0,0);
    chk("addr_100", int'(mem_addr), 100);
    step(0,0,1,0,0,0);
    chk("early_fe_addr0", int'(mem_addr), 0);
    for (int i = 0; i < 5; i++) step(0,0,1,0,0,0);

    // Reset mid-fetch: silent until the next frame_end.
    step(1,0,0,0,0,0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_pv", int'(pix_valid), 0);
    pv_cnt = 0;
    for (int i = 0; i < 8; i++) step(0,0,0,0,0,0);
    chk("rst_no_pix", pv_cnt, 0);

    // Starved write during full-rate prefetch.
    step(0,1,0,0,0,0);
    for (int i = 0; i < 20; i++)
      step(0,0,m_cred != 16,0,0,0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(0,0,m_cred != 16,1,16'hABCD,6'h33);
      n++;
      if (wr_ack) break;
    end
    chk("starve_ack_cycle", n, 9);
    chk("starve_we", int'(mem_we), 1);
    chk("starve_addr", int'(mem_addr), 'hABCD);
    chk("starve_data", int'(mem_wdata), 'h33);
    step(0,0,m_cred != 16,0,0,0);
    chk("resume_we", int'(mem_we), 0);

    // Run to end of frame at full rate.
    for (int i = 0; i < 70000 && m_state != 2; i++)
      step(0,0,m_cred != 16,0,0,0);
    chk("frame_done_addr", int'(mem_addr), FBW - 1);
    for (int i = 0; i < 10; i++) step(0,0,m_cred != 16,0,0,0);
    chk("done_hold_addr", int'(mem_addr), FBW - 1);

    // Randomized traffic.
    step(1,0,0,0,0,0);
    step(0,1,0,0,0,0);
    pend = 0; pa = '0; pd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend && $urandom_range(0,3) == 0) begin
        pend = 1;
        pa = 16'($urandom_range(0,255));
        pd = 6'($urandom);
      end
      step($urandom_range(0,1499) == 0,
           $urandom_range(0,399) == 0,
           $urandom_range(0,1) == 1,
           pend, pa, pd);
      if (wr_ack || rst) pend = 0;
      if (rst) step(0,1,0,0,0,0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
